nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that feeds one 4-bit ripple_adder_4bit_dataflow slice one nibble
//  per cycle, LSB nibble first, and registers the carry between nibbles.

---
 rtl/nibble_serial_adder_pkg.sv | 9 +
 rtl/nibble_serial_adder_ripple.sv | 15 +
 rtl/nibble_serial_adder.sv | 92 +++++++++
 tb/tb_nibble_serial_adder.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared nibble width and FSM state encoding for the nibble-serial adder
package nibble_serial_adder_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_serial_adder_ripple.sv
// ripple_adder_4bit_dataflow: 4-bit ripple-carry adder slice built from continuous assignments
module ripple_adder_4bit_dataflow (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic c1, c2, c3;
    assign c1   = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
    assign c2   = (a[1] & b[1]) | ((a[1] ^ b[1]) & c1);
    assign c3   = (a[2] & b[2]) | ((a[2] ^ b[2]) & c2);
    assign cout = (a[3] & b[3]) | ((a[3] ^ b[3]) & c3);
    assign sum  = a ^ b ^ {c3, c2, c1, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit slice per cycle, LSB nibble first
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int N  = WIDTH / NIBBLE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_n;
    logic             c_reg;
    logic [1:0]       msb;
    logic [CW-1:0]    cnt;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             last;
    logic             accept;

    ripple_adder_4bit_dataflow u_slice (
        .a   (a_sh[3:0]),
        .b   (b_sh[3:0]),
        .cin (c_reg),
        .sum (nib_sum),
        .cout(nib_cout)
    );

    assign last      = cnt == CW'(N - 1);
    assign in_ready  = !(state == ST_RUN || state == ST_DONE);
    assign out_valid = state == ST_DONE;
    assign accept    = in_valid && in_ready;
    // nibble results enter at the top so the first (LSB) nibble ends up at bit 0
    assign res_n     = (res >> NIBBLE_W) | (WIDTH'(nib_sum) << (WIDTH - NIBBLE_W));

    always_comb begin
        state_n = state == ST_RUN  ? (last ? ST_DONE : ST_RUN) :
                  state == ST_DONE ? (out_ready ? ST_IDLE : ST_DONE) :
                                     (in_valid ? ST_RUN : ST_IDLE);
    end

    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            c_reg     <= 1'b0;
            msb       <= 2'b00;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            c_reg <= carry_in;
            msb   <= {a[WIDTH-1], b[WIDTH-1]};
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            c_reg <= nib_cout;
            res   <= res_n;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum       <= res_n;
                carry_out <= nib_cout;
                overflow  <= (msb[1] == msb[0]) && (res_n[WIDTH-1] != msb[1]);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random adds on 16- and 4-bit instances, checked against plain integer arithmetic
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, carry_in, out_valid, out_ready, carry_out, overflow;
    logic [15:0] a, b, sum;
    logic        w4_in_valid, w4_in_ready, w4_cin, w4_out_valid, w4_out_ready, w4_cout, w4_ovf;
    logic [3:0]  w4_a, w4_b, w4_sum;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready), .a(w4_a), .b(w4_b),
        .carry_in(w4_cin), .out_valid(w4_out_valid), .out_ready(w4_out_ready), .sum(w4_sum),
        .carry_out(w4_cout), .overflow(w4_ovf)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {overflow, carry_out, sum} from ordinary integer addition
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] s;
        s = {1'b0, x} + {1'b0, y} + {16'd0, c};
        return {(x[15] == y[15]) && (s[15] != x[15]), s};
    endfunction

    task automatic add16(input logic [15:0] x, input logic [15:0] y, input logic c,
                         input int hold, input logic poke);
        logic [17:0] e;
        int k;
        e = ref_add(x, y, c);
        k = 0;
        while (!in_ready && k < 20) begin cyc(); k++; end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = x; b = y; carry_in = c; in_valid = 1'b1;
        k = 0;
        cyc();
        k = 1;
        in_valid = 1'b0;
        if (poke) begin
            a = 16'hAAAA; b = 16'hAAAA; carry_in = 1'b1; in_valid = 1'b1;
        end
        while (!out_valid && k < 20) begin
            cyc();
            in_valid = 1'b0;
            k++;
        end
        check("latency", 32'(k), 32'd5);
        check("sum", 32'(sum), 32'(e[15:0]));
        check("carry_out", 32'(carry_out), 32'(e[16]));
        check("overflow", 32'(overflow), 32'(e[17]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'h5555; b = 16'h1111;
            cyc();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(e[15:0]));
            check("hold_cout", 32'(carry_out), 32'(e[16]));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("post_handshake_valid", 32'(out_valid), 32'd0);
        check("post_handshake_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b0;
        w4_in_valid = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0; w4_out_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_w4_in_ready", 32'(w4_in_ready), 32'd1);

        add16(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        check("t1_sum_const", 32'(sum), 32'h0000);
        check("t1_cout_const", 32'(carry_out), 32'd1);
        add16(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
        check("t2_sum_const", 32'(sum), 32'h5556);
        add16(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        check("t2_ovf_const", 32'(overflow), 32'd1);
        add16(16'h8000, 16'h8000, 1'b0, 3, 1'b0);
        add16(16'h0F0F, 16'h0101, 1'b0, 0, 1'b1);
        check("t4_sum_const", 32'(sum), 32'h1010);

        for (int i = 0; i < 20; i++)
            add16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

        a = 16'h1111; b = 16'h2222; carry_in = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_run_in_ready", 32'(in_ready), 32'd1);
        check("rst_run_out_valid", 32'(out_valid), 32'd0);
        check("rst_run_sum", 32'(sum), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("rst_run_no_result", 32'(out_valid), 32'd0);
        end
        add16(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);
        check("t5_sum_const", 32'(sum), 32'h1000);

        w4_a = 4'hF; w4_b = 4'h1; w4_cin = 1'b1; w4_in_valid = 1'b1;
        cyc();
        k = 1;
        w4_in_valid = 1'b0;
        while (!w4_out_valid && k < 20) begin cyc(); k++; end
        check("w4_latency", 32'(k), 32'd2);
        check("w4_sum", 32'(w4_sum), 32'h1);
        check("w4_cout", 32'(w4_cout), 32'd1);
        check("w4_ovf", 32'(w4_ovf), 32'd0);
        w4_out_ready = 1'b1;
        cyc();
        w4_out_ready = 1'b0;
        check("w4_post_valid", 32'(w4_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
